// File: rtl/radix3_butterfly_pipe_pkg.sv
// Shared FFT constants: the sqrt(3)/2 twiddle in Q1.15 and its rounding offset.
package radix3_butterfly_pipe_pkg;

    // round(sqrt(3)/2 * 2^15)
    localparam int unsigned K_COEF = 28378;
    // fraction bits of K_COEF
    localparam int unsigned K_FRAC = 15;
    // half an LSB of the Q1.15 product, added before the arithmetic shift
    localparam int unsigned K_RND  = 16384;
    // signed width needed to hold K_COEF
    localparam int unsigned K_W    = 16;

endpackage

// File: rtl/radix3_butterfly_pipe_mul.sv
// const_mul_k: signed constant multiply by K with round-half-up back to the input width.
module const_mul_k
    import radix3_butterfly_pipe_pkg::*;
#(
    parameter int unsigned IN_W = 17
) (
    input  logic signed [IN_W-1:0] din,
    output logic signed [IN_W-1:0] dout_c
);

    localparam int unsigned PW = IN_W + K_W;

    logic signed [PW-1:0] din_x;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] sum;

    // |K| < 1, so the rounded product always fits back into IN_W bits
    always_comb begin
        din_x  = PW'(din);
        prod   = din_x * $signed(PW'(K_COEF));
        sum    = prod + $signed(PW'(K_RND));
        dout_c = IN_W'(sum >>> K_FRAC);
    end

endmodule

// File: rtl/radix3_butterfly_pipe.sv
// Three-stage radix-3 DFT butterfly with valid/ready flow control and a shared stall.
module radix3_butterfly_pipe
    import radix3_butterfly_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   a_re,
    input  logic [WIDTH-1:0]   a_img,
    input  logic [WIDTH-1:0]   b_re,
    input  logic [WIDTH-1:0]   b_img,
    input  logic [WIDTH-1:0]   c_re,
    input  logic [WIDTH-1:0]   c_img,
    input  logic               inv,
    input  logic [TAG_W-1:0]   in_tag,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH+1:0]   x0_re,
    output logic [WIDTH+1:0]   x0_img,
    output logic [WIDTH+1:0]   x1_re,
    output logic [WIDTH+1:0]   x1_img,
    output logic [WIDTH+1:0]   x2_re,
    output logic [WIDTH+1:0]   x2_img,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int unsigned SW = WIDTH + 1;
    localparam int unsigned OW = WIDTH + 2;

    logic advance;

    // stage 1 registers
    logic                    v1;
    logic                    inv1;
    logic [TAG_W-1:0]        tag1;
    logic signed [WIDTH-1:0] a_re1, a_im1;
    logic signed [SW-1:0]    s_re1, s_im1, d_re1, d_im1;

    // stage 2 registers
    logic                    v2;
    logic                    inv2;
    logic [TAG_W-1:0]        tag2;
    logic signed [OW-1:0]    x0_re2, x0_im2, h_re2, h_im2;
    logic signed [SW-1:0]    p_re2, p_im2;

    logic signed [SW-1:0]    p_re_c, p_im_c;
    logic signed [OW-1:0]    y1_re_c, y1_im_c, y2_re_c, y2_im_c;

    // one enable for every stage: move whenever the output slot is free or being drained
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // stage 1: sum and difference of b and c
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            inv1  <= 1'b0;
            tag1  <= '0;
            a_re1 <= '0;
            a_im1 <= '0;
            s_re1 <= '0;
            s_im1 <= '0;
            d_re1 <= '0;
            d_im1 <= '0;
        end else if (advance) begin
            v1    <= in_valid;
            inv1  <= inv;
            tag1  <= in_tag;
            a_re1 <= $signed(a_re);
            a_im1 <= $signed(a_img);
            s_re1 <= SW'($signed(b_re)) + SW'($signed(c_re));
            s_im1 <= SW'($signed(b_img)) + SW'($signed(c_img));
            d_re1 <= SW'($signed(b_re)) - SW'($signed(c_re));
            d_im1 <= SW'($signed(b_img)) - SW'($signed(c_img));
        end
    end

    const_mul_k #(.IN_W(SW)) u_mul_re (.din(d_re1), .dout_c(p_re_c));
    const_mul_k #(.IN_W(SW)) u_mul_im (.din(d_im1), .dout_c(p_im_c));

    // stage 2: DC term, half-sum offset and scaled difference
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2     <= 1'b0;
            inv2   <= 1'b0;
            tag2   <= '0;
            x0_re2 <= '0;
            x0_im2 <= '0;
            h_re2  <= '0;
            h_im2  <= '0;
            p_re2  <= '0;
            p_im2  <= '0;
        end else if (advance) begin
            v2     <= v1;
            inv2   <= inv1;
            tag2   <= tag1;
            x0_re2 <= OW'(a_re1) + OW'(s_re1);
            x0_im2 <= OW'(a_im1) + OW'(s_im1);
            h_re2  <= OW'(a_re1) - OW'(s_re1 >>> 1);
            h_im2  <= OW'(a_im1) - OW'(s_im1 >>> 1);
            p_re2  <= p_re_c;
            p_im2  <= p_im_c;
        end
    end

    // stage 3 combine: rotate p by -j (forward); inverse swaps the two outputs
    always_comb begin
        y1_re_c = h_re2 + OW'(p_im2);
        y1_im_c = h_im2 - OW'(p_re2);
        y2_re_c = h_re2 - OW'(p_im2);
        y2_im_c = h_im2 + OW'(p_re2);
        if (inv2) begin
            y1_re_c = h_re2 - OW'(p_im2);
            y1_im_c = h_im2 + OW'(p_re2);
            y2_re_c = h_re2 + OW'(p_im2);
            y2_im_c = h_im2 - OW'(p_re2);
        end
    end

    // stage 3: output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_tag   <= '0;
            x0_re     <= '0;
            x0_img    <= '0;
            x1_re     <= '0;
            x1_img    <= '0;
            x2_re     <= '0;
            x2_img    <= '0;
        end else if (advance) begin
            out_valid <= v2;
            out_tag   <= tag2;
            x0_re     <= x0_re2;
            x0_img    <= x0_im2;
            x1_re     <= y1_re_c;
            x1_img    <= y1_im_c;
            x2_re     <= y2_re_c;
            x2_img    <= y2_im_c;
        end
    end

endmodule

// File: tb/tb_radix3_butterfly_pipe.sv
// Randomised bench for radix3_butterfly_pipe against an integer reference model.
module tb_radix3_butterfly_pipe;

    localparam int unsigned W  = 16;
    localparam int unsigned TW = 4;

    typedef struct {
        logic [TW-1:0] tag;
        longint x0r, x0i, x1r, x1i, x2r, x2i;
        longint acc;
        bit     strict;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [W-1:0] a_re = '0, a_img = '0, b_re = '0, b_img = '0, c_re = '0, c_img = '0;
    logic inv = 1'b0;
    logic [TW-1:0] in_tag = '0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [W+1:0] x0_re, x0_img, x1_re, x1_img, x2_re, x2_img;
    logic [TW-1:0] out_tag;
    logic out_valid;
    logic out_ready = 1'b1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mode = 0;
    int pat = 0;
    logic [TW-1:0] tag_ctr = '0;
    exp_t exp_q[$];

    bit stall_prev = 1'b0;
    logic [W+1:0] snap[6];
    logic [TW-1:0] snap_tag;

    radix3_butterfly_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_re(a_re), .a_img(a_img), .b_re(b_re), .b_img(b_img), .c_re(c_re), .c_img(c_img),
        .inv(inv), .in_tag(in_tag), .in_valid(in_valid), .in_ready(in_ready),
        .x0_re(x0_re), .x0_img(x0_img), .x1_re(x1_re), .x1_img(x1_img),
        .x2_re(x2_re), .x2_img(x2_img),
        .out_tag(out_tag), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint got, input longint want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    function automatic longint rnd_k(input longint v);
        return (28378 * v + 16384) >>> 15;
    endfunction

    // radix-3 DFT with the fixed-point twiddle approximation
    function automatic exp_t model(input int ar, ai, br, bi, cr, ci, input bit iv);
        exp_t e;
        longint sr, si, dr, di, hr, hi, pr, pi;
        sr = br + cr;  si = bi + ci;
        dr = br - cr;  di = bi - ci;
        hr = ar - (sr >>> 1);
        hi = ai - (si >>> 1);
        pr = rnd_k(dr);
        pi = rnd_k(di);
        e.x0r = ar + sr;
        e.x0i = ai + si;
        if (!iv) begin
            e.x1r = hr + pi; e.x1i = hi - pr;
            e.x2r = hr - pi; e.x2i = hi + pr;
        end else begin
            e.x1r = hr - pi; e.x1i = hi + pr;
            e.x2r = hr + pi; e.x2i = hi - pr;
        end
        e.tag = '0;
        e.acc = 0;
        e.strict = 1'b0;
        return e;
    endfunction

    function automatic longint sx(input logic [W+1:0] v);
        return longint'($signed(v));
    endfunction

    // out_ready pattern generator
    always begin
        @(posedge clk);
        #1;
        pat++;
        case (mode)
            1:       out_ready = ((pat % 3) == 0);
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b1;
        endcase
    end

    // compare process: handshakes are stable between the falling edge and the next rising edge
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            chk("in_ready_rule", longint'(in_ready), longint'(!out_valid || out_ready));
            if (stall_prev) begin
                chk("stall_hold_valid", longint'(out_valid), 1);
                chk("stall_hold_tag", longint'(out_tag), longint'(snap_tag));
                chk("stall_hold_x0re", sx(x0_re), sx(snap[0]));
                chk("stall_hold_x1im", sx(x1_img), sx(snap[3]));
                chk("stall_hold_x2re", sx(x2_re), sx(snap[4]));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output tag=%0d expected=none (cycle %0d)", out_tag, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_tag", longint'(out_tag), longint'(e.tag));
                    chk("x0_re", sx(x0_re), e.x0r);
                    chk("x0_img", sx(x0_img), e.x0i);
                    chk("x1_re", sx(x1_re), e.x1r);
                    chk("x1_img", sx(x1_img), e.x1i);
                    chk("x2_re", sx(x2_re), e.x2r);
                    chk("x2_img", sx(x2_img), e.x2i);
                    if (e.strict && mode == 0)
                        chk("latency", longint'(cyc) - e.acc, 3);
                    else
                        chk("latency_min", longint'((longint'(cyc) - e.acc) >= 3), 1);
                end
            end
            if (in_valid && in_ready) begin
                e = model(int'($signed(a_re)), int'($signed(a_img)), int'($signed(b_re)),
                          int'($signed(b_img)), int'($signed(c_re)), int'($signed(c_img)), inv);
                e.tag = in_tag;
                e.acc = longint'(cyc);
                e.strict = (mode == 0);
                exp_q.push_back(e);
            end
            stall_prev = out_valid && !out_ready;
            snap[0] = x0_re;  snap[1] = x0_img; snap[2] = x1_re;
            snap[3] = x1_img; snap[4] = x2_re;  snap[5] = x2_img;
            snap_tag = out_tag;
        end
    end

    // present one sample and hold it until accepted (called at posedge+1)
    task automatic send(input logic [W-1:0] ar, ai, br, bi, cr, ci, input logic iv);
        bit acc;
        acc = 1'b0;
        a_re = ar; a_img = ai; b_re = br; b_img = bi; c_re = cr; c_img = ci;
        inv = iv;
        in_tag = tag_ctr;
        in_valid = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout tag=%0d got=not_accepted expected=accepted", tag_ctr);
        end
        tag_ctr = tag_ctr + 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        send(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
             16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(posedge clk);
        #1;
        chk("drain_queue_empty", longint'(exp_q.size()), 0);
    endtask

    initial begin
        exp_t m;

        // pin the reference model to hand-computed results
        m = model(100, 0, 0, 0, 0, 0, 1'b0);
        chk("model_dc_x1re", m.x1r, 100);
        chk("model_dc_x2re", m.x2r, 100);
        m = model(0, 0, 1000, 0, 0, 0, 1'b0);
        chk("model_fwd_x1re", m.x1r, -500);
        chk("model_fwd_x1im", m.x1i, -866);
        chk("model_fwd_x2im", m.x2i, 866);
        m = model(0, 0, 1000, 0, 0, 0, 1'b1);
        chk("model_inv_x1im", m.x1i, 866);
        chk("model_inv_x2im", m.x2i, -866);
        m = model(32767, 32767, 32767, 32767, 32767, 32767, 1'b0);
        chk("model_max_x0re", m.x0r, 98301);
        chk("model_max_x1re", m.x1r, 0);
        m = model(-32768, -32768, -32768, -32768, -32768, -32768, 1'b0);
        chk("model_min_x0im", m.x0i, -98304);
        chk("model_min_x2im", m.x2i, 0);

        // reset state
        #3;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_x0_re", sx(x0_re), 0);
        chk("rst_x2_img", sx(x2_img), 0);
        chk("rst_out_tag", longint'(out_tag), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // directed corner vectors, back to back
        mode = 0;
        send(16'd100, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);
        send(16'd0, 16'd0, 16'd1000, 16'd0, 16'd0, 16'd0, 1'b0);
        send(16'd0, 16'd0, 16'd1000, 16'd0, 16'd0, 16'd0, 1'b1);
        send(16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff, 1'b0);
        send(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b1);
        drain();

        // eight tagged samples under a 1,0,0 out_ready pattern
        tag_ctr = '0;
        mode = 1;
        for (int i = 0; i < 8; i++) send_rand();
        mode = 0;
        drain();

        // back-to-back random samples, out_ready held high
        for (int i = 0; i < 200; i++) send_rand();
        drain();

        // random gaps and random back-pressure
        mode = 2;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send_rand();
        end
        mode = 0;
        drain();

        // reset with two samples in flight
        tag_ctr = 4'hE;
        send(16'd1234, 16'd55, 16'd7, 16'd900, 16'd3, 16'd11, 1'b0);
        send(16'd4321, 16'd66, 16'd8, 16'd800, 16'd4, 16'd22, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", longint'(out_valid), 0);
        chk("midrst_x1_re", sx(x1_re), 0);
        chk("midrst_out_tag", longint'(out_tag), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("postrst_in_ready", longint'(in_ready), 1);
        repeat (6) @(posedge clk);
        #1;
        tag_ctr = 4'h3;
        send(16'd100, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/radix3_butterfly_pipe.md
RADIX3_BUTTERFLY_PIPE -- requirements
Module: radix3_butterfly_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, signed two's-complement input component width (valid range 8..24).
REQ-002 SHALL have parameter TAG_W, default 4, width of the sideband tag carried alongside each sample.
REQ-003 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports a_re, a_img, b_re, b_img, c_re, c_img  in  WIDTH each  three complex input points.
REQ-006 SHALL have port inv  in  1  per-sample mode: 0 forward DFT, 1 inverse (conjugate twiddles).
REQ-007 SHALL have port in_tag  in  TAG_W  sideband, returned unchanged with the result.
REQ-008 SHALL have ports in_valid  in  1 and in_ready  out  1  input handshake.
REQ-009 SHALL have ports x0_re, x0_img, x1_re, x1_img, x2_re, x2_img  out  WIDTH+2 each  three complex outputs.
REQ-010 SHALL have ports out_tag  out  TAG_W, out_valid  out  1, out_ready  in  1  output handshake.

Function
REQ-011 SHALL accept a sample when in_valid && in_ready on a rising edge; SHALL present a result when out_valid, consumed when out_valid && out_ready.
REQ-012 SHALL be a 3-stage pipeline: S1 s=b+c, d=b-c, register a/inv/tag; S2 h=a-(s>>>1), p=rnd(K*d); S3 final add/subtract.
REQ-013 K SHALL be the Q1.15 constant 28378 (round(sqrt(3)/2 * 2^15)); rnd(K*v) = (K*v + 2^14) >>> 15, arithmetic.
REQ-014 s>>>1 SHALL be an arithmetic shift (floor); s and d are WIDTH+1 bits, h and outputs WIDTH+2 bits; no saturation needed or applied.
REQ-015 Forward: x0=a+s; x1_re=h_re+p_im; x1_img=h_im-p_re; x2_re=h_re-p_im; x2_img=h_im+p_re, with p=rnd(K*d) per component.
REQ-016 Inverse (inv=1): x0 as forward; x1 and x2 values SHALL be exchanged relative to forward; no 1/3 scaling.
REQ-017 Latency SHALL be exactly 3 cycles from acceptance to out_valid when out_ready is held high; throughput one sample per cycle.
REQ-018 Pipeline SHALL advance when !out_valid || out_ready; in_ready SHALL equal this advance condition (combinational from out_ready and out_valid).
REQ-019 On stall (out_valid && !out_ready) all stage registers, outputs and out_tag SHALL hold; no sample lost or duplicated.
REQ-020 Bubbles SHALL propagate: each stage carries a valid bit; out_valid is the S3 valid bit.
REQ-021 Simultaneous output consumption and input acceptance in one cycle SHALL be supported with no bubble inserted.
REQ-022 inv and in_tag SHALL travel with their sample; changing inv between samples SHALL affect only the samples sampled with it.

Reset
REQ-023 On rst_n low, all stage valid bits and out_valid SHALL clear to 0 immediately (asynchronously); x*_re/x*_img and out_tag SHALL reset to 0.
REQ-024 Reset asserted mid-operation SHALL discard all in-flight samples; after deassertion in_ready=1 and first out_valid no earlier than 3 cycles after the next acceptance.

Structure
REQ-025 K (28378), its fraction width (15) and the rounding offset SHALL live in the shared FFT package; WIDTH/TAG_W stay module parameters.
REQ-026 The constant multiply-round SHALL be a sub-module named const_mul_k (signed in, rounded out), instanced twice (d_re, d_im).
REQ-027 Stage-enable logic SHALL be a single advance signal shared by all stages; no per-stage ready chain.

Verification
REQ-028 a=(100,0), b=c=(0,0), inv=0 -> after 3 cycles x0=x1=x2=(100,0).
REQ-029 a=(0,0), b=(1000,0), c=(0,0), inv=0 -> x0=(1000,0), x1=(-500,-866), x2=(-500,866); same with inv=1 -> x1=(-500,866), x2=(-500,-866).
REQ-030 a=b=c=(32767,32767), WIDTH=16 -> x0=(98301,98301), x1=x2=(0,0); a=b=c=(-32768,-32768) -> x0=(-98304,-98304), x1=x2=(0,0).
REQ-031 Stream 8 samples with tags 0..7, out_ready toggled 1,0,0,1,... -> all 8 results in tag order, values match model, none duplicated, in_ready low exactly when out_valid && !out_ready.
REQ-032 Accept 2 samples, assert rst_n low 1 cycle later -> out_valid=0 at once, outputs 0; neither sample ever appears; next sample after release emerges after 3 cycles.
REQ-033 Random back-to-back samples with out_ready=1 and random inv -> one result per cycle, 3-cycle latency, bit-exact versus reference model of REQ-013..016.
